// File: rtl/perf_pkg.sv
// perf_pkg: constants and types shared by perf_sampler, its FIFO and the
// upstream performance_counter block.
//   PERF_BASE      - base address of the counter map
//   NUM_PERF_WORDS - counter words per snapshot
//   FRAME_WORDS    - header plus counter words in one frame
//   HDR_MAGIC      - tag carried in the top byte of each frame header
//   perf_state_e   - sampler FSM state encoding
//   perf_word_offset() - byte offset of counter word idx in the map
package perf_pkg;

    localparam logic [31:0] PERF_BASE      = 32'h3000_0000;
    localparam int          NUM_PERF_WORDS = 6;
    localparam int          FRAME_WORDS    = NUM_PERF_WORDS + 1;
    localparam logic [7:0]  HDR_MAGIC      = 8'hA5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HDR  = 2'd1,
        ST_READ = 2'd2
    } perf_state_e;

    // Counter words are 32 bits wide and packed at consecutive word addresses.
    function automatic logic [31:0] perf_word_offset(input logic [7:0] idx);
        return {22'd0, idx, 2'b00};
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock first-word-fall-through FIFO.
//   clk, rst       - clock, asynchronous active-low reset (flushes pointers)
//   push/push_data - write one entry (ignored when full)
//   pop            - drop the head entry (ignored when empty)
//   head           - current head entry, forced to zero while empty
//   count          - registered number of stored entries
// DEPTH must be a power of two so the pointers wrap naturally.
module sync_fifo #(
    parameter int WIDTH = 33,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           head,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int              AW        = $clog2(DEPTH);
    localparam logic [AW:0]     CNT_ZERO  = {(AW+1){1'b0}};
    localparam logic [AW:0]     CNT_ONE   = {{AW{1'b0}}, 1'b1};
    localparam logic [AW:0]     CNT_FULL  = (AW+1)'(DEPTH);
    localparam logic [AW-1:0]   PTR_ONE   = {{(AW-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [AW:0]      count_r;
    logic             wr_en_s;
    logic             rd_en_s;

    assign wr_en_s = push && (count_r != CNT_FULL);
    assign rd_en_s = pop  && (count_r != CNT_ZERO);

    // Storage array; contents are don't-care until the count covers them.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_r[wr_ptr_r] <= push_data;
        end
    end

    // Read/write pointers and occupancy count.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= CNT_ZERO;
        end else begin
            if (wr_en_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (rd_en_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({wr_en_s, rd_en_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

    assign head  = (count_r == CNT_ZERO) ? {WIDTH{1'b0}} : mem_r[rd_ptr_r];
    assign count = count_r;

endmodule

// File: rtl/perf_sampler.sv
// perf_sampler: periodic snapshot engine for performance_counter.
// Sweeps the counter words through the debug read port and queues each sweep
// as a header-tagged frame for a valid/ready consumer.
//   clk, rst              - clock, asynchronous active-low reset
//   enable                - runs the sample period counter
//   sample_now            - one-cycle software trigger
//   debug_addr/debug_read - read port driven toward performance_counter
//   debug_data            - combinational read data returned in the same cycle
//   out_data/out_last     - FIFO head word and end-of-frame tag
//   out_valid/out_ready   - stream handshake
//   busy                  - a frame is being built
//   drop_count            - saturating count of rejected triggers
module perf_sampler #(
    parameter logic [31:0] PERF_BASE     = perf_pkg::PERF_BASE,
    parameter int          NUM_WORDS     = perf_pkg::NUM_PERF_WORDS,
    parameter int          SAMPLE_PERIOD = 1000,
    parameter int          FIFO_DEPTH    = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        sample_now,
    output logic [31:0] debug_addr,
    output logic        debug_read,
    input  logic [31:0] debug_data,
    output logic [31:0] out_data,
    output logic        out_last,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        busy,
    output logic [15:0] drop_count
);

    import perf_pkg::*;

    localparam logic [1:0] IDLE = ST_IDLE;
    localparam logic [1:0] HDR  = ST_HDR;
    localparam logic [1:0] READ = ST_READ;

    localparam int                PCNT_W     = $clog2(SAMPLE_PERIOD);
    localparam logic [PCNT_W-1:0] PCNT_LAST  = PCNT_W'(SAMPLE_PERIOD - 1);
    localparam logic [PCNT_W-1:0] PCNT_ONE   = PCNT_W'(1);
    localparam logic [PCNT_W-1:0] PCNT_ZERO  = PCNT_W'(0);
    localparam int                CNT_W      = $clog2(FIFO_DEPTH) + 1;
    // A frame is accepted only if the whole frame fits: count <= depth - frame.
    localparam logic [CNT_W-1:0]  MAX_FILL   = CNT_W'(FIFO_DEPTH - NUM_WORDS - 1);
    localparam logic [CNT_W-1:0]  CNT_ZERO   = CNT_W'(0);
    localparam logic [7:0]        LAST_IDX   = 8'(NUM_WORDS - 1);

    logic [1:0]        state_r;
    logic [1:0]        state_nxt_s;
    logic [7:0]        idx_r;
    logic [7:0]        idx_nxt_s;
    logic [15:0]       seq_r;
    logic [15:0]       drop_count_r;
    logic [31:0]       debug_addr_r;
    logic              debug_read_r;
    logic              busy_r;
    logic [PCNT_W-1:0] pcnt_r;

    logic              auto_trig_s;
    logic              trig_s;
    logic              space_ok_s;
    logic              last_word_s;
    logic              push_s;
    logic [32:0]       push_data_s;
    logic              pop_s;
    logic              drop_inc_s;
    logic              seq_inc_s;
    logic [32:0]       head_s;
    logic [CNT_W-1:0]  fifo_count_s;

    // Sample period counter: wraps at the period while enabled, parked at zero otherwise.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pcnt_r <= PCNT_ZERO;
        end else if (!enable) begin
            pcnt_r <= PCNT_ZERO;
        end else if (pcnt_r == PCNT_LAST) begin
            pcnt_r <= PCNT_ZERO;
        end else begin
            pcnt_r <= pcnt_r + PCNT_ONE;
        end
    end

    assign auto_trig_s = enable && (pcnt_r == PCNT_LAST);
    assign trig_s      = auto_trig_s || sample_now;
    // The registered count is used as-is; a pop in the trigger cycle is not credited.
    assign space_ok_s  = (fifo_count_s <= MAX_FILL);
    assign last_word_s = (idx_r == LAST_IDX);

    // Frame FSM: next state, FIFO push and drop/sequence events.
    always_comb begin
        state_nxt_s = state_r;
        idx_nxt_s   = idx_r;
        push_s      = 1'b0;
        push_data_s = 33'd0;
        drop_inc_s  = 1'b0;
        seq_inc_s   = 1'b0;
        case (state_r)
            IDLE: begin
                if (trig_s) begin
                    if (space_ok_s) begin
                        state_nxt_s = HDR;
                    end else begin
                        drop_inc_s = 1'b1;
                    end
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            HDR: begin
                push_s      = 1'b1;
                push_data_s = {1'b0, HDR_MAGIC, 8'(NUM_WORDS), seq_r};
                idx_nxt_s   = 8'd0;
                state_nxt_s = READ;
                drop_inc_s  = trig_s;
            end
            READ: begin
                push_s      = 1'b1;
                push_data_s = {last_word_s, debug_data};
                drop_inc_s  = trig_s;
                if (last_word_s) begin
                    state_nxt_s = IDLE;
                    seq_inc_s   = 1'b1;
                end else begin
                    idx_nxt_s = idx_r + 8'd1;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // FSM state, word index and frame sequence number.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= IDLE;
            idx_r   <= 8'd0;
            seq_r   <= 16'd0;
        end else begin
            state_r <= state_nxt_s;
            idx_r   <= idx_nxt_s;
            if (seq_inc_s) begin
                seq_r <= seq_r + 16'd1;
            end
        end
    end

    // Read port and busy are computed from the next state so they line up with READ cycles.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            debug_read_r <= 1'b0;
            debug_addr_r <= 32'd0;
            busy_r       <= 1'b0;
        end else begin
            debug_read_r <= (state_nxt_s == READ);
            debug_addr_r <= (state_nxt_s == READ) ? (PERF_BASE + perf_word_offset(idx_nxt_s))
                                                  : 32'd0;
            busy_r       <= (state_nxt_s != IDLE);
        end
    end

    // Saturating count of rejected triggers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            drop_count_r <= 16'd0;
        end else if (drop_inc_s && (drop_count_r != 16'hFFFF)) begin
            drop_count_r <= drop_count_r + 16'd1;
        end else begin
            drop_count_r <= drop_count_r;
        end
    end

    assign pop_s = out_valid && out_ready;

    sync_fifo #(
        .WIDTH (33),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push_s),
        .push_data (push_data_s),
        .pop       (pop_s),
        .head      (head_s),
        .count     (fifo_count_s)
    );

    assign out_valid  = (fifo_count_s != CNT_ZERO);
    assign out_data   = head_s[31:0];
    assign out_last   = head_s[32];
    assign debug_addr = debug_addr_r;
    assign debug_read = debug_read_r;
    assign busy       = busy_r;
    assign drop_count = drop_count_r;

endmodule

// File: tb/tb_perf_sampler.sv
// tb_perf_sampler: self-checking bench for perf_sampler with a short sample
// period and a debug_data stub returning the low address byte. Expected
// stream words are queued when a frame is launched and compared as the
// consumer accepts them.
module tb_perf_sampler;

    logic        clk;
    logic        rst;
    logic        enable;
    logic        sample_now;
    logic [31:0] debug_addr;
    logic        debug_read;
    logic [31:0] debug_data;
    logic [31:0] out_data;
    logic        out_last;
    logic        out_valid;
    logic        out_ready;
    logic        busy;
    logic [15:0] drop_count;

    int total = 0;
    int bad   = 0;
    logic [32:0] exp_q[$];
    logic [15:0] exp_drop;

    typedef struct {
        logic        rd;
        logic [31:0] addr;
        logic        bsy;
        logic        vld;
    } row_t;
    row_t rows [9];

    perf_sampler #(
        .PERF_BASE     (32'h3000_0000),
        .NUM_WORDS     (6),
        .SAMPLE_PERIOD (16),
        .FIFO_DEPTH    (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .sample_now (sample_now),
        .debug_addr (debug_addr),
        .debug_read (debug_read),
        .debug_data (debug_data),
        .out_data   (out_data),
        .out_last   (out_last),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .busy       (busy),
        .drop_count (drop_count)
    );

    assign debug_data = {24'd0, debug_addr[7:0]};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [32:0] act, input logic [32:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic push_frame(input logic [15:0] s);
        exp_q.push_back({1'b0, 8'hA5, 8'h06, s});
        for (int i = 0; i < 6; i++) begin
            exp_q.push_back({(i == 5), 32'(4 * i)});
        end
    endtask

    // Trigger in the cycle after the call; returns mid-way through that frame's HDR cycle.
    task automatic pulse();
        @(negedge clk) sample_now = 1'b1;
        @(negedge clk) sample_now = 1'b0;
    endtask

    task automatic drain_wait();
        int n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain_timeout: got %0d words left want 0", exp_q.size());
            exp_q.delete();
        end
        repeat (2) @(negedge clk);
        chk("empty_valid", {32'd0, out_valid}, 33'd0);
        chk("empty_data", {out_last, out_data}, 33'd0);
    endtask

    // Consumer-side scoreboard: every accepted word must match the queue head.
    always @(negedge clk) begin
        if (rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL stream_extra: got %h want no word", {out_last, out_data});
            end else begin
                chk("stream", {out_last, out_data}, exp_q.pop_front());
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rows[0] = '{1'b0, 32'h0000_0000, 1'b1, 1'b0};
        rows[1] = '{1'b1, 32'h3000_0000, 1'b1, 1'b1};
        rows[2] = '{1'b1, 32'h3000_0004, 1'b1, 1'b1};
        rows[3] = '{1'b1, 32'h3000_0008, 1'b1, 1'b1};
        rows[4] = '{1'b1, 32'h3000_000C, 1'b1, 1'b1};
        rows[5] = '{1'b1, 32'h3000_0010, 1'b1, 1'b1};
        rows[6] = '{1'b1, 32'h3000_0014, 1'b1, 1'b1};
        rows[7] = '{1'b0, 32'h0000_0000, 1'b0, 1'b1};
        rows[8] = '{1'b0, 32'h0000_0000, 1'b0, 1'b0};

        rst        = 1'b0;
        enable     = 1'b0;
        sample_now = 1'b0;
        out_ready  = 1'b1;
        exp_drop   = 16'd0;

        // Reset values
        repeat (3) @(negedge clk);
        chk("rst_addr",  {1'b0, debug_addr}, 33'd0);
        chk("rst_read",  {32'd0, debug_read}, 33'd0);
        chk("rst_data",  {out_last, out_data}, 33'd0);
        chk("rst_valid", {32'd0, out_valid}, 33'd0);
        chk("rst_busy",  {32'd0, busy}, 33'd0);
        chk("rst_drop",  {17'd0, drop_count}, 33'd0);
        rst = 1'b1;
        @(negedge clk);

        // Auto triggers at period 16: exactly two frames before enable drops
        push_frame(16'd0);
        push_frame(16'd1);
        enable = 1'b1;
        repeat (35) @(negedge clk);
        enable = 1'b0;
        drain_wait();

        // Software trigger with enable low: cycle-by-cycle timing table
        push_frame(16'd2);
        pulse();
        for (int r = 0; r < 9; r++) begin
            chk($sformatf("t%0d_read", r + 1),  {32'd0, debug_read}, {32'd0, rows[r].rd});
            chk($sformatf("t%0d_addr", r + 1),  {1'b0, debug_addr},  {1'b0, rows[r].addr});
            chk($sformatf("t%0d_busy", r + 1),  {32'd0, busy},       {32'd0, rows[r].bsy});
            chk($sformatf("t%0d_valid", r + 1), {32'd0, out_valid},  {32'd0, rows[r].vld});
            @(negedge clk);
        end
        drain_wait();

        // Back-pressure: first frame stored, second trigger dropped for lack of space
        out_ready = 1'b0;
        push_frame(16'd3);
        pulse();
        repeat (18) @(negedge clk);
        pulse();
        exp_drop = exp_drop + 16'd1;
        chk("bp_drop",  {17'd0, drop_count}, {17'd0, exp_drop});
        chk("bp_valid", {32'd0, out_valid}, 33'd1);
        chk("bp_busy",  {32'd0, busy}, 33'd0);
        out_ready = 1'b1;
        drain_wait();
        push_frame(16'd4);
        pulse();
        drain_wait();

        // sample_now held through the whole frame: 7 in-frame triggers dropped
        push_frame(16'd5);
        @(negedge clk) sample_now = 1'b1;
        repeat (8) @(negedge clk);
        sample_now = 1'b0;
        exp_drop = exp_drop + 16'd7;
        chk("hold_drop", {17'd0, drop_count}, {17'd0, exp_drop});
        drain_wait();

        // Reset during READ idx 3 aborts the frame and flushes the FIFO
        out_ready = 1'b0;
        pulse();
        repeat (4) @(negedge clk);
        chk("pre_rst_addr", {1'b0, debug_addr}, {1'b0, 32'h3000_000C});
        rst = 1'b0;
        #1;
        chk("arst_addr",  {1'b0, debug_addr}, 33'd0);
        chk("arst_read",  {32'd0, debug_read}, 33'd0);
        chk("arst_data",  {out_last, out_data}, 33'd0);
        chk("arst_valid", {32'd0, out_valid}, 33'd0);
        chk("arst_busy",  {32'd0, busy}, 33'd0);
        chk("arst_drop",  {17'd0, drop_count}, 33'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        exp_drop = 16'd0;
        @(negedge clk);
        chk("post_rst_valid", {32'd0, out_valid}, 33'd0);
        out_ready = 1'b1;
        push_frame(16'd0);
        pulse();
        drain_wait();

        // Sequence wrap from 16'hFFFF to 0
        @(negedge clk) force dut.seq_r = 16'hFFFF;
        @(negedge clk) release dut.seq_r;
        push_frame(16'hFFFF);
        pulse();
        drain_wait();
        push_frame(16'h0000);
        pulse();
        drain_wait();

        // drop_count saturation: one accepted frame, then >65535 rejected triggers
        out_ready = 1'b0;
        push_frame(16'h0001);
        @(negedge clk) sample_now = 1'b1;
        repeat (70000) @(negedge clk);
        sample_now = 1'b0;
        @(negedge clk);
        chk("sat_drop", {17'd0, drop_count}, {17'd0, 16'hFFFF});
        out_ready = 1'b1;
        drain_wait();
        chk("sat_hold", {17'd0, drop_count}, {17'd0, 16'hFFFF});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/perf_sampler.md
# perf_sampler

Periodic snapshot engine downstream of `performance_counter`. It drives that block's debug read port (`debug_addr`/`debug_read`) and captures the combinational `debug_data` response, sweeping the six counter words. Each sweep becomes one header-tagged frame in a small FIFO, which drains over a valid/ready stream toward the SPI transmit path.

## Interface
Parameters:
- `PERF_BASE`, 32'h3000_0000: base address of the counter map.
- `NUM_WORDS`, 6: counter words per frame, at addresses +0 to +20 in steps of 4.
- `SAMPLE_PERIOD`, 1000: cycles between automatic triggers. Legal values are ≥ 16.
- `FIFO_DEPTH`, 8: FIFO entries. Must be a power of 2 and ≥ NUM_WORDS+1.

Ports:
- `clk`, input, 1: sole clock, rising edge.
- `rst`, input, 1: asynchronous, active-low reset.
- `enable`, input, 1: runs the period counter.
- `sample_now`, input, 1: one-cycle software trigger. Honoured regardless of `enable`.
- `debug_addr`, output, 32: counter address, driven to `performance_counter`.
- `debug_read`, output, 1: read strobe. `debug_data` is sampled in the same cycle.
- `debug_data`, input, 32: counter value returned by `performance_counter`.
- `out_data`, output, 32: FIFO head word.
- `out_last`, output, 1: head word is the last word of its frame.
- `out_valid`, output, 1: FIFO not empty.
- `out_ready`, input, 1: consumer accepts the head word.
- `busy`, output, 1: a frame is in progress.
- `drop_count`, output, 16: count of dropped triggers. Saturates at 16'hFFFF.

## Operation
- Period counter:
  - While `enable` is high, it counts 0 to SAMPLE_PERIOD-1 and wraps.
  - The cycle in which it equals SAMPLE_PERIOD-1 raises an auto trigger.
  - While `enable` is low, it is held at 0.
  - Trigger = auto trigger OR `sample_now`. Simultaneous sources count as one trigger.
- Frame format: one header word, then NUM_WORDS data words.
  - Header = {8'hA5, NUM_WORDS[7:0], seq[15:0]}.
  - Data word i = `debug_data` read at PERF_BASE+4·i.
  - `out_last` is set only on data word NUM_WORDS-1.
- `seq` is a 16-bit frame number. It increments after every frame that is emitted, wraps at 16'hFFFF to 0, and is reset to 0.
- State machine:
  - IDLE: on a trigger with free space ≥ NUM_WORDS+1, go to HDR. On a trigger without that space, stay in IDLE and increment `drop_count`.
  - HDR: push the header, clear idx, go to READ.
  - READ: assert `debug_read` with `debug_addr` = PERF_BASE+4·idx, push `debug_data` with the `out_last` tag, increment idx. When idx = NUM_WORDS-1, go to IDLE and increment `seq`.
- Free space = FIFO_DEPTH − registered count in the trigger cycle. A pop in that same cycle is not credited.
- Because space is reserved up front, pushes never stall and a frame is never split or truncated.
- Triggers in HDR or READ are dropped and increment `drop_count`.
- `enable` falling mid-frame: the frame completes.
- FIFO:
  - First-word fall-through: `out_data`/`out_last` show the head.
  - A pop happens on `out_valid && out_ready`.
  - A simultaneous push and pop in one cycle leaves the count unchanged.
  - When the FIFO is empty, `out_data` and `out_last` are forced to 0.
- Counters keep advancing during a sweep. Each word reflects the counter value in its own read cycle; sweep coherence is not guaranteed.

## Timing
- Trigger in cycle t:
  - HDR in t+1.
  - READ in t+2 to t+1+NUM_WORDS.
  - IDLE in t+2+NUM_WORDS (t+8 for the default), where a new trigger is accepted.
- The header is visible on `out_valid`/`out_data` at t+2. The consumer has zero-wait throughput.
- `busy` = (state ≠ IDLE), registered.
- `debug_read` is high only in READ cycles. When it is low, `debug_addr` = 0.
- Reset values: `debug_addr` 0, `debug_read` 0, `out_data` 0, `out_last` 0, `out_valid` 0, `busy` 0, `drop_count` 0. The period counter, `seq` and FIFO pointers are all 0.
- Reset asserted mid-frame aborts the frame immediately and flushes the FIFO.

## Structure
- Package `perf_pkg` holds:
  - PERF_BASE, NUM_PERF_WORDS = 6, HDR_MAGIC = 8'hA5.
  - FRAME_WORDS = NUM_PERF_WORDS+1.
  - The state enum {IDLE, HDR, READ}.
  - The counter address offsets, shared with `performance_counter`.
- Sub-module `sync_fifo`: 33 bits wide ({last, data}), FIFO_DEPTH deep, with an exposed count. The FSM, period counter and header logic stay in `perf_sampler`.

## Test plan
- SAMPLE_PERIOD=16, `enable`=1, `out_ready`=1, stubbed `debug_data` = addr[7:0] -> a frame every 16 cycles:
  - Header 32'hA506_0000, then 0,4,8,12,16,20, with `out_last` on 20.
  - Next header 32'hA506_0001.
- `enable`=0 and `sample_now` pulse at t -> header visible at t+2; `debug_read` high t+2 to t+7 at addresses 3000_0000 to 3000_0014.
- `out_ready`=0 with two triggers 20 cycles apart -> first frame stored (7 entries); second dropped and `drop_count`=1. After draining, the next frame carries seq 1.
- `sample_now` held high during a frame -> every trigger cycle in HDR/READ increments `drop_count`; the frame is intact.
- `rst` low in READ idx 3 -> all outputs 0 and FIFO empty. After release, the first frame carries seq 0.
- 70000 triggers with `out_ready`=0 -> `drop_count` saturates at 16'hFFFF; separately, the seq wrap 16'hFFFF→0 is checked.
